// File: rtl/adc_cfg_pkg.sv
// Shared types and constants for the ADC serial configuration engine.
package adc_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_NEXT
  } state_e;

  localparam int unsigned DEF_NUM_ADC = 12;
  localparam int unsigned DEF_WORD_W  = 24;
  localparam int unsigned DEF_DEPTH   = 32;

  localparam int unsigned ADDR_W   = $clog2(DEF_DEPTH);
  localparam int unsigned BITCNT_W = $clog2(DEF_WORD_W + 1);
  localparam int unsigned CHIP_W   = $clog2(DEF_NUM_ADC);

  localparam logic RST_SCLK  = 1'b1;
  localparam logic RST_SDATA = 1'b0;
  localparam logic RST_BUSY  = 1'b0;
  localparam logic RST_DONE  = 1'b0;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_serial_cfg_if.sv
// Control handshake plus the shared serial bus of the ADC configurator.
interface adc_serial_cfg_if #(
  parameter int unsigned NUM_ADC = 12
);
  logic               START;
  logic               MODE;
  logic [NUM_ADC-1:0] MASK;
  logic [NUM_ADC-1:0] CS;
  logic               SCLK;
  logic               SDATA;
  logic               BUSY;
  logic               DONE;

  modport master (output START, MODE, MASK, input CS, SCLK, SDATA, BUSY, DONE);
  modport slave  (input START, MODE, MASK, output CS, SCLK, SDATA, BUSY, DONE);
endinterface

// File: rtl/adc_sclk_gen.sv
// SCLK divider: idles high, toggles every SCLK_HALF clocks while enabled,
// flags the clock in which each falling/rising edge is being registered.
module adc_sclk_gen
  import adc_cfg_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic sclk_o,
  output logic fall_strobe_o,
  output logic rise_strobe_o
);
  localparam int unsigned      CW   = width_of(SCLK_HALF);
  localparam logic [CW-1:0]    LAST = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          tick;

  assign tick          = en_i && (cnt_q == LAST);
  assign fall_strobe_o = tick && sclk_q;
  assign rise_strobe_o = tick && !sclk_q;
  assign sclk_o        = sclk_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      sclk_q <= RST_SCLK;
    end else if (!en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else if (tick) begin
      cnt_q  <= '0;
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/adc_serial_cfg.sv
// Serial configuration engine: streams RAM words 0..LAST_ADDR MSB-first to the
// masked ADCs, either all at once or one chip after another.
module adc_serial_cfg
  import adc_cfg_pkg::*;
#(
  parameter int unsigned NUM_ADC   = 12,
  parameter int unsigned WORD_W    = 24,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned LAST_ADDR = 16,
  parameter int unsigned SCLK_HALF = 1,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  adc_serial_cfg_if.slave               bus,
  input  logic                          MEM_WE,
  input  logic [width_of(DEPTH)-1:0]    MEM_WADDR,
  input  logic [WORD_W-1:0]             MEM_WDATA,
  input  logic [width_of(DEPTH)-1:0]    MEM_RADDR,
  output logic [WORD_W-1:0]             MEM_RDATA
);
  localparam int unsigned AW = width_of(DEPTH);
  localparam int unsigned BW = $clog2(WORD_W + 1);
  localparam int unsigned IW = width_of(NUM_ADC);
  localparam int unsigned GW = $clog2(CS_GAP + 1);

  logic [WORD_W-1:0]  mem_q [DEPTH];
  state_e             state_q;
  logic               mode_q;
  logic [NUM_ADC-1:0] mask_q;
  logic [NUM_ADC-1:0] cs_q;
  logic [AW-1:0]      addr_q;
  logic [IW-1:0]      chip_q;
  logic [BW-1:0]      bitcnt_q;
  logic [GW-1:0]      gap_q;
  logic [WORD_W-1:0]  shreg_q;
  logic               busy_q;
  logic               done_q;

  logic               sclk, fall_stb, rise_stb;
  logic [IW-1:0]      first_idx_d, next_idx_d;
  logic               next_found_d;
  logic               last_word;
  logic [GW-1:0]      gap_end;

  function automatic logic [NUM_ADC-1:0] onehot(input logic [IW-1:0] idx);
    return NUM_ADC'(1) << idx;
  endfunction

  always_ff @(posedge CLK) begin
    if (MEM_WE) mem_q[MEM_WADDR] <= MEM_WDATA;
  end
  assign MEM_RDATA = mem_q[MEM_RADDR];

  // Lowest masked chip overall, and lowest masked chip above the current one.
  always_comb begin
    first_idx_d  = '0;
    next_idx_d   = '0;
    next_found_d = 1'b0;
    for (int unsigned i = NUM_ADC; i > 0; i--) begin
      if (bus.MASK[i-1]) first_idx_d = IW'(i - 1);
      if (mask_q[i-1] && ((i - 1) > 32'(chip_q))) begin
        next_idx_d   = IW'(i - 1);
        next_found_d = 1'b1;
      end
    end
  end

  // NEXT doubles as the final gap cycle of a pass, so GAP is one cycle
  // shorter after the last word and a pass stays a whole number of frames.
  assign last_word = (addr_q == AW'(LAST_ADDR));
  assign gap_end   = last_word ? GW'(CS_GAP - 2) : GW'(CS_GAP - 1);

  adc_sclk_gen #(.SCLK_HALF(SCLK_HALF)) u_sclk (
    .clk_i         (CLK),
    .rst_n_i       (RST_N),
    .en_i          (state_q == ST_SHIFT),
    .sclk_o        (sclk),
    .fall_strobe_o (fall_stb),
    .rise_strobe_o (rise_stb)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      mask_q   <= '0;
      cs_q     <= '0;
      addr_q   <= '0;
      chip_q   <= '0;
      bitcnt_q <= '0;
      gap_q    <= '0;
      shreg_q  <= {WORD_W{RST_SDATA}};
      busy_q   <= RST_BUSY;
      done_q   <= RST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.START) begin
          mode_q   <= bus.MODE;
          mask_q   <= bus.MASK;
          busy_q   <= 1'b1;
          done_q   <= 1'b0;
          addr_q   <= '0;
          chip_q   <= first_idx_d;
          gap_q    <= '0;
          if (bus.MASK == '0) begin
            state_q <= ST_NEXT;
          end else begin
            state_q <= ST_LOAD;
            cs_q    <= bus.MODE ? onehot(first_idx_d) : bus.MASK;
          end
        end
        ST_LOAD: begin
          shreg_q  <= mem_q[addr_q];
          bitcnt_q <= '0;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (fall_stb && (bitcnt_q != '0)) shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
          if (rise_stb) begin
            bitcnt_q <= bitcnt_q + BW'(1);
            if (bitcnt_q == BW'(WORD_W - 1)) state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          cs_q    <= '0;
          gap_q   <= '0;
          state_q <= (last_word && (CS_GAP == 1)) ? ST_NEXT : ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == gap_end) begin
            gap_q <= '0;
            if (last_word) begin
              state_q <= ST_NEXT;
            end else begin
              addr_q  <= addr_q + AW'(1);
              state_q <= ST_LOAD;
              cs_q    <= mode_q ? onehot(chip_q) : mask_q;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        ST_NEXT: begin
          if (mode_q && next_found_d) begin
            chip_q  <= next_idx_d;
            addr_q  <= '0;
            state_q <= ST_LOAD;
            cs_q    <= onehot(next_idx_d);
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.CS    = cs_q;
  assign bus.SCLK  = sclk;
  assign bus.SDATA = shreg_q[WORD_W-1];
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
endmodule

// File: tb/tb_adc_serial_cfg.sv
// Bench for adc_serial_cfg: default build plus a narrow, slow-SCLK build.
module tb_adc_serial_cfg;
  localparam int NA = 12, WA = 24, DA = 32, LA = 16, HA = 1, GA = 2;
  localparam int NB = 4,  WB = 16, DB = 8,  LB = 3,  HB = 3, GB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  adc_serial_cfg_if #(.NUM_ADC(NA)) ifa ();
  adc_serial_cfg_if #(.NUM_ADC(NB)) ifb ();

  logic          we_a, we_b;
  logic [4:0]    wa_a, ra_a;
  logic [2:0]    wa_b, ra_b;
  logic [23:0]   wd_a, rd_a;
  logic [15:0]   wd_b, rd_b;

  adc_serial_cfg #(.NUM_ADC(NA), .WORD_W(WA), .DEPTH(DA), .LAST_ADDR(LA),
                   .SCLK_HALF(HA), .CS_GAP(GA)) dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(ifa), .MEM_WE(we_a), .MEM_WADDR(wa_a),
    .MEM_WDATA(wd_a), .MEM_RADDR(ra_a), .MEM_RDATA(rd_a));

  adc_serial_cfg #(.NUM_ADC(NB), .WORD_W(WB), .DEPTH(DB), .LAST_ADDR(LB),
                   .SCLK_HALF(HB), .CS_GAP(GB)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(ifb), .MEM_WE(we_b), .MEM_WADDR(wa_b),
    .MEM_WDATA(wd_b), .MEM_RADDR(ra_b), .MEM_RDATA(rd_b));

  typedef struct {
    logic [63:0] cs;
    logic [63:0] word;
    int          bits;
    int          hi;
    bit          chg;
  } frame_t;

  typedef struct {
    bit           mode;
    logic [11:0]  mask;
    int           cycles;
  } vec_t;

  int passed = 0, total = 0;
  frame_t fa[$], fb[$], exp_q[$];
  logic [63:0] memA [32];
  logic [63:0] memB [32];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference: the word list each pass should carry and the sequence length.
  function automatic int build_exp(bit mode, logic [63:0] mask, int n, int last,
                                   int h, int w, int g, logic [63:0] m [32]);
    logic [63:0] passes[$];
    exp_q.delete();
    if (mode) begin
      for (int i = 0; i < n; i++) if (mask[i]) passes.push_back(64'd1 << i);
    end else if (mask != 0) begin
      passes.push_back(mask);
    end
    foreach (passes[p])
      for (int a = 0; a <= last; a++)
        exp_q.push_back('{passes[p], m[a], w, 2 + 2*h*w, 1'b0});
    return (passes.size() == 0) ? 1 : passes.size() * (last + 1) * (2 + 2*h*w + g);
  endfunction

  task automatic compare(string tag, input frame_t got[$]);
    chk({tag, "_nframes"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_f%0d_cs", tag, i), got[i].cs, exp_q[i].cs);
      chk($sformatf("%s_f%0d_word", tag, i), got[i].word, exp_q[i].word);
      chk($sformatf("%s_f%0d_bits", tag, i), got[i].bits, exp_q[i].bits);
      chk($sformatf("%s_f%0d_cshigh", tag, i), got[i].hi, exp_q[i].hi);
      chk($sformatf("%s_f%0d_cs_steady", tag, i), got[i].chg, 0);
    end
  endtask

  // Bus monitors: assemble SDATA sampled on SCLK rise into frames per CS window.
  logic [63:0] pcs_a = 0, cur_a = 0, pcs_b = 0, cur_b = 0;
  logic ps_a = 1'b1, ps_b = 1'b1;
  int bits_a, hi_a, lo_a, bits_b, hi_b, lo_b, cyc_b = 0, lr_b = 0;
  bit chg_a, chg_b;

  always @(negedge clk) begin
    if (64'(ifa.CS) != 0) begin
      if (pcs_a == 0) begin
        if (fa.size() > 0) chk("gap_a", lo_a, GA);
        cur_a = 0; bits_a = 0; hi_a = 0; chg_a = 0;
      end else if (64'(ifa.CS) != pcs_a) chg_a = 1;
      hi_a++;
      if (ifa.SCLK && !ps_a) begin cur_a = {cur_a[62:0], ifa.SDATA}; bits_a++; end
    end else begin
      if (pcs_a != 0) begin fa.push_back('{pcs_a, cur_a, bits_a, hi_a, chg_a}); lo_a = 0; end
      lo_a++;
    end
    pcs_a = 64'(ifa.CS);
    ps_a  = ifa.SCLK;
  end

  always @(negedge clk) begin
    cyc_b++;
    if (64'(ifb.CS) != 0) begin
      if (pcs_b == 0) begin
        if (fb.size() > 0) chk("gap_b", lo_b, GB);
        cur_b = 0; bits_b = 0; hi_b = 0; chg_b = 0;
      end else if (64'(ifb.CS) != pcs_b) chg_b = 1;
      hi_b++;
      if (ifb.SCLK && !ps_b) begin
        if (bits_b > 0) chk("sclk_period_b", cyc_b - lr_b, 2*HB);
        lr_b = cyc_b;
        cur_b = {cur_b[62:0], ifb.SDATA};
        bits_b++;
      end
    end else begin
      if (pcs_b != 0) begin fb.push_back('{pcs_b, cur_b, bits_b, hi_b, chg_b}); lo_b = 0; end
      lo_b++;
    end
    pcs_b = 64'(ifb.CS);
    ps_b  = ifb.SCLK;
  end

  task automatic write_a(int a, logic [23:0] d);
    @(negedge clk); we_a = 1'b1; wa_a = 5'(a); wd_a = d; memA[a] = 64'(d);
    @(negedge clk); we_a = 1'b0;
  endtask

  task automatic write_b(int a, logic [15:0] d);
    @(negedge clk); we_b = 1'b1; wa_b = 3'(a); wd_b = d; memB[a] = 64'(d);
    @(negedge clk); we_b = 1'b0;
  endtask

  task automatic run_a(string tag, bit mode, logic [NA-1:0] mask, int exp_cyc, bit inj);
    int cyc;
    bit wrote, restarted;
    fa.delete();
    @(negedge clk); ifa.START = 1'b1; ifa.MODE = mode; ifa.MASK = mask;
    @(negedge clk); ifa.START = 1'b0; ifa.MODE = 1'($urandom); ifa.MASK = NA'($urandom);
    chk({tag, "_busy_on"}, ifa.BUSY, 1);
    chk({tag, "_done_clr"}, ifa.DONE, 0);
    cyc = 0; wrote = 0; restarted = 0;
    while (!ifa.DONE && cyc < exp_cyc + 64) begin
      we_a = 1'b0; ifa.START = 1'b0;
      if (inj && !wrote && fa.size() == 2 && ifa.CS != '0) begin
        we_a = 1'b1; wa_a = 5'd5; wd_a = 24'hABCDEF; memA[5] = 64'hABCDEF; wrote = 1;
      end
      if (inj && !restarted && fa.size() == 3) begin
        ifa.START = 1'b1; ifa.MODE = 1'b1; ifa.MASK = 12'h001; restarted = 1;
      end
      @(negedge clk); cyc++;
    end
    we_a = 1'b0; ifa.START = 1'b0;
    chk({tag, "_done_cycles"}, cyc, exp_cyc);
    chk({tag, "_busy_off"}, ifa.BUSY, 0);
    void'(build_exp(mode, 64'(mask), NA, LA, HA, WA, GA, memA));
    compare(tag, fa);
    repeat (3) @(negedge clk);
    chk({tag, "_done_hold"}, ifa.DONE, 1);
  endtask

  task automatic run_b(string tag, bit mode, logic [NB-1:0] mask, int exp_cyc);
    int cyc;
    fb.delete();
    @(negedge clk); ifb.START = 1'b1; ifb.MODE = mode; ifb.MASK = mask;
    @(negedge clk); ifb.START = 1'b0; ifb.MASK = '0;
    cyc = 0;
    while (!ifb.DONE && cyc < exp_cyc + 64) begin @(negedge clk); cyc++; end
    chk({tag, "_done_cycles"}, cyc, exp_cyc);
    void'(build_exp(mode, 64'(mask), NB, LB, HB, WB, GB, memB));
    compare(tag, fb);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int cyc, ex;
    bit m;
    logic [NA-1:0] mk;

    tbl = '{'{1'b0, 12'hFFF, 884}, '{1'b1, 12'h005, 1768}, '{1'b0, 12'h000, 1},
            '{1'b1, 12'h800, 884}, '{1'b0, 12'h0A0, 884}};
    foreach (memA[i]) memA[i] = 0;
    foreach (memB[i]) memB[i] = 0;
    rst_n = 1'b0;
    ifa.START = 0; ifa.MODE = 0; ifa.MASK = '0;
    ifb.START = 0; ifb.MODE = 0; ifb.MASK = '0;
    we_a = 0; wa_a = 0; wd_a = 0; ra_a = 0;
    we_b = 0; wa_b = 0; wd_b = 0; ra_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs", ifa.CS, 0);
    chk("rst_sclk", ifa.SCLK, 1);
    chk("rst_sdata", ifa.SDATA, 0);
    chk("rst_busy", ifa.BUSY, 0);
    chk("rst_done", ifa.DONE, 0);
    chk("rst_b_sclk", ifb.SCLK, 1);
    rst_n = 1'b1;

    for (int i = 0; i <= LA; i++) write_a(i, 24'(i));
    for (int i = 0; i <= LB; i++) write_b(i, 16'($urandom));

    foreach (tbl[i]) run_a($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].mask, tbl[i].cycles, 0);

    // RAM write while word 2 is on the wire, plus a START that must be ignored.
    run_a("wr_busy", 1'b0, 12'hFFF, 884, 1);
    ra_a = 5'd5; #1;
    chk("rdata_5", rd_a, 24'hABCDEF);

    // Reset in the middle of word 7.
    fa.delete();
    @(negedge clk); ifa.START = 1'b1; ifa.MODE = 1'b0; ifa.MASK = 12'hFFF;
    @(negedge clk); ifa.START = 1'b0;
    cyc = 0;
    while (!(fa.size() == 7 && ifa.CS != '0 && bits_a >= 3) && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    chk("rst_mid_reached", fa.size(), 7);
    rst_n = 1'b0; #1;
    chk("rst_mid_cs", ifa.CS, 0);
    chk("rst_mid_sclk", ifa.SCLK, 1);
    chk("rst_mid_sdata", ifa.SDATA, 0);
    chk("rst_mid_busy", ifa.BUSY, 0);
    chk("rst_mid_done", ifa.DONE, 0);
    repeat (3) @(negedge clk);
    #1; fa.delete(); rst_n = 1'b1;
    ra_a = 5'd5; #1;
    chk("rst_ram_kept", rd_a, memA[5][23:0]);
    run_a("rst_rerun", 1'b0, 12'hFFF, 884, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i <= LA; i++) write_a(i, 24'($urandom));
      m  = 1'($urandom);
      mk = NA'($urandom & $urandom & $urandom);
      ex = build_exp(m, 64'(mk), NA, LA, HA, WA, GA, memA);
      run_a($sformatf("rnd%0d", r), m, mk, ex, 0);
    end

    run_b("b_bcast", 1'b0, 4'hF, 408);
    run_b("b_seq", 1'b1, 4'hA, 816);
    run_b("b_none", 1'b0, 4'h0, 1);
    chk("b_cs_idle", ifb.CS, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
